uarc_io_bridge: RTL
===================

UARC_IO_BRIDGE -- requirements
Module: uarc_io_bridge

Interface
REQ-001 The block SHALL have one clock and SHALL use an asynchronous, active-high reset.
REQ-002 Parameter: WORD_WIDTH, default 32, core bus word width.
REQ-003 Parameter: CHANNELS, default 2, number of independent peripheral channels (bus indices).
REQ-004 Parameter: PERIPH_WIDTH, default 8, peripheral character width; SHALL be at most WORD_WIDTH.
REQ-005 Parameter: FIFO_ADDR_WIDTH, default 3; each FIFO depth SHALL be 2^FIFO_ADDR_WIDTH.
REQ-006 Ports (name, direction, width, meaning), one per line:
- clk  in  1  system clock
- reset  in  1  async active-high reset
- rx_valid  in  CHANNELS  peripheral character strobe per channel
- rx_data  in  CHANNELS*PERIPH_WIDTH  peripheral characters
- rx_overflow  out  CHANNELS  one-cycle pulse: character dropped, FIFO full
- receiver_sends  out  CHANNELS  word pending toward core
- receiver_send_acks  in  CHANNELS  core consumed head word
- receiver_datas  out  CHANNELS*WORD_WIDTH  head word per channel
- sender_enables  in  CHANNELS  core-selected destination channels
- global_send  in  1  core send request
- global_data  in  WORD_WIDTH  core send payload
- sender_send_acks  out  CHANNELS  send accepted per channel
- tx_valid  out  CHANNELS  character available to peripheral
- tx_data  out  CHANNELS*PERIPH_WIDTH  head character per channel
- tx_ready  in  CHANNELS  peripheral accepts head character

Function
REQ-007 Each channel SHALL contain one RX FIFO and one TX FIFO, both first-word-fall-through.
REQ-008 RX push: on a clock edge with rx_valid[i]=1 and RX FIFO i not full, rx_data[i] SHALL be written; receiver_sends[i] SHALL be 1 from the next cycle.
REQ-009 receiver_sends[i] SHALL equal RX FIFO i not-empty; receiver_datas[i] SHALL be the head zero-extended to WORD_WIDTH.
REQ-010 RX pop: receiver_send_acks[i]=1 while receiver_sends[i]=1 SHALL pop the head. An ack while the FIFO is empty SHALL be ignored.
REQ-011 Simultaneous RX push and pop SHALL both take effect, including when the FIFO is full; occupancy SHALL then be unchanged.
REQ-012 rx_valid[i]=1 with RX FIFO i full and no same-cycle pop SHALL drop the character and pulse rx_overflow[i] for exactly the next cycle.
REQ-013 TX broadcast: the block SHALL compute a combinational go = global_send AND (sender_enables != 0) AND every enabled channel's TX FIFO is not full.
REQ-014 sender_send_acks[i] SHALL equal go AND sender_enables[i]. Acks SHALL be all-or-nothing across enabled channels.
REQ-015 When go=1, global_data[PERIPH_WIDTH-1:0] SHALL be pushed into every enabled TX FIFO at that edge; tx_valid SHALL be 1 on those channels from the next cycle.
REQ-016 tx_valid[i] SHALL equal TX FIFO i not-empty; tx_data[i] SHALL be the head; tx_valid[i] AND tx_ready[i] SHALL pop the head.
REQ-017 A full TX FIFO SHALL accept a push in the cycle it is popped; the go computation SHALL use occupancy before the edge, so it does not rely on that same-cycle pop.
REQ-018 FIFO pointers SHALL wrap modulo depth; occupancy counters SHALL be FIFO_ADDR_WIDTH+1 bits wide, with full at count = depth.
REQ-019 Channels SHALL be fully independent except for the shared TX go term.

Reset
REQ-020 Asserting reset SHALL immediately clear all pointers, counters and rx_overflow. receiver_sends, sender_send_acks and tx_valid SHALL read 0 while reset is high.
REQ-021 Reset mid-transfer SHALL discard all buffered data; no stale head SHALL appear after release.
REQ-022 FIFO storage arrays SHALL NOT require reset.

Structure
REQ-023 Package uarc_io_pkg SHALL hold default parameter constants (WORD_WIDTH, PERIPH_WIDTH, FIFO_ADDR_WIDTH) and the per-channel FIFO status struct (count, empty, full).
REQ-024 Sub-module uarc_fifo (parametrised width and depth, FWFT, push/pop/full/empty/count) SHALL be instantiated 2*CHANNELS times.

Verification
REQ-025 Push RX ch0 0x41, ch1 0x42 in one cycle -> the next cycle receiver_sends=2'b11 and receiver_datas = 0x00000041, 0x00000042; ack both -> receiver_sends=0.
REQ-026 Push 9 chars to RX ch0 (depth 8) with no ack -> 8 stored, rx_overflow[0] pulses once on the 9th; 8 acks return the first 8 chars in order.
REQ-027 Fill TX ch1 (8 entries, tx_ready=0), sender_enables=2'b11, global_send=1, data 0x5A -> sender_send_acks=0 on both channels. Raise tx_ready[1] for one cycle -> the next cycle acks=2'b11 and 0x5A is queued on both channels.
REQ-028 RX ch0 full with rx_valid and ack in the same cycle -> count stays 8, no overflow, ordering preserved.
REQ-029 Assert reset with 3 RX and 5 TX entries pending -> all valid/sends are 0 immediately; after release, a new push of 0x33 appears as the head.
REQ-030 global_send=1 with sender_enables=0 -> no acks and no FIFO change.

Source files
------------

// File: rtl/uarc_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uarc_io_pkg
//  Description : Shared constants and types for the UARC I/O bridge.
//                Holds the default bus/character/FIFO sizing and the
//                per-channel FIFO status record used by the bridge top.
//  Revision    : 1.0 - initial release
// ============================================================================
package uarc_io_pkg;

  // Default sizing of the bridge
  localparam int c_word_width      = 32;
  localparam int c_periph_width    = 8;
  localparam int c_fifo_addr_width = 3;

  // The status count field is wide enough for any practical FIFO size;
  // the real occupancy (FIFO_ADDR_WIDTH+1 bits) is zero-extended into it.
  localparam int c_status_count_width = 16;

  typedef struct packed {
    logic [c_status_count_width-1:0] count;
    logic                            empty;
    logic                            full;
  } fifo_status_t;

endpackage : uarc_io_pkg
`default_nettype wire

// File: rtl/uarc_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uarc_fifo
//  Description : First-word-fall-through FIFO, depth 2**ADDR_WIDTH.
//                The head entry is always visible on rdata while not empty.
//                A push into a full FIFO is accepted when a pop happens in
//                the same cycle.
//  Ports       : clk, reset (async, active-high)
//                push/wdata  - write request and data
//                pop         - consume head (ignored when empty)
//                rdata       - head entry
//                full/empty  - occupancy flags
//                count       - occupancy, ADDR_WIDTH+1 bits
//  Revision    : 1.0 - initial release
// ============================================================================
module uarc_fifo #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rdata,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_depth = (ADDR_WIDTH + 1)'(DEPTH);

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;

  logic w_do_pop;
  logic w_do_push;

  assign empty = (r_count == '0);
  assign full  = (r_count == c_depth);

  // A pop frees the slot the write lands in, so full + pop still accepts.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  // Pointers are ADDR_WIDTH bits wide, so they wrap modulo depth naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is deliberately not reset; the cleared count hides stale data.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  assign rdata = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule : uarc_fifo
`default_nettype wire

// File: rtl/uarc_io_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : uarc_io_bridge
//  Description : Bridges CHANNELS peripheral character streams to a core
//                word bus. Each channel owns an RX FIFO (peripheral -> core)
//                and a TX FIFO (core -> peripheral). Core sends are broadcast
//                to all enabled channels and accepted all-or-nothing.
//  Ports       : clk, reset            - clock, async active-high reset
//                rx_valid/rx_data      - incoming peripheral characters
//                rx_overflow           - one-cycle pulse, character dropped
//                receiver_sends/datas  - RX head word per channel toward core
//                receiver_send_acks    - core consumed RX head
//                sender_enables        - destination channel mask
//                global_send/data      - core send request and payload
//                sender_send_acks      - per-channel send acceptance
//                tx_valid/tx_data      - TX head character per channel
//                tx_ready              - peripheral consumed TX head
//  Note        : PERIPH_WIDTH must not exceed WORD_WIDTH.
//  Revision    : 1.0 - initial release
// ============================================================================
module uarc_io_bridge
  import uarc_io_pkg::*;
#(
  parameter int WORD_WIDTH      = c_word_width,
  parameter int CHANNELS        = 2,
  parameter int PERIPH_WIDTH    = c_periph_width,
  parameter int FIFO_ADDR_WIDTH = c_fifo_addr_width
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [CHANNELS-1:0]              rx_valid,
  input  logic [CHANNELS*PERIPH_WIDTH-1:0] rx_data,
  output logic [CHANNELS-1:0]              rx_overflow,
  output logic [CHANNELS-1:0]              receiver_sends,
  input  logic [CHANNELS-1:0]              receiver_send_acks,
  output logic [CHANNELS*WORD_WIDTH-1:0]   receiver_datas,
  input  logic [CHANNELS-1:0]              sender_enables,
  input  logic                             global_send,
  input  logic [WORD_WIDTH-1:0]            global_data,
  output logic [CHANNELS-1:0]              sender_send_acks,
  output logic [CHANNELS-1:0]              tx_valid,
  output logic [CHANNELS*PERIPH_WIDTH-1:0] tx_data,
  input  logic [CHANNELS-1:0]              tx_ready
);

  fifo_status_t w_rx_status [CHANNELS];
  fifo_status_t w_tx_status [CHANNELS];

  logic [CHANNELS-1:0]     r_rx_overflow;
  logic [CHANNELS-1:0]     w_tx_push;
  logic [CHANNELS-1:0]     w_tx_pop;
  logic [PERIPH_WIDTH-1:0] w_tx_char;
  logic                    w_tx_blocked;
  logic                    w_go;

  assign w_tx_char = global_data[PERIPH_WIDTH-1:0];

  // Broadcast go: decided from pre-edge occupancy only, so a TX FIFO that is
  // full is never counted on the peripheral draining it in the same cycle.
  // Reset forces go low so no ack is shown while the bridge is held in reset.
  always_comb begin
    w_tx_blocked = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sender_enables[i] && w_tx_status[i].full) begin
        w_tx_blocked = 1'b1;
      end
    end
    w_go = !reset && global_send && (|sender_enables) && !w_tx_blocked;
  end

  assign sender_send_acks = {CHANNELS{w_go}} & sender_enables;
  assign w_tx_push        = sender_send_acks;
  assign rx_overflow      = r_rx_overflow;

  // A full FIFO is never empty, so an ack there always pops and makes room;
  // only a character arriving at a full FIFO without an ack is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_overflow <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_rx_overflow[i] <= rx_valid[i] && w_rx_status[i].full
                            && !receiver_send_acks[i];
      end
    end
  end

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      logic [PERIPH_WIDTH-1:0]  w_rx_head;
      logic [PERIPH_WIDTH-1:0]  w_tx_head;
      logic [FIFO_ADDR_WIDTH:0] w_rx_count;
      logic [FIFO_ADDR_WIDTH:0] w_tx_count;
      logic                     w_rx_full;
      logic                     w_rx_empty;
      logic                     w_tx_full;
      logic                     w_tx_empty;

      uarc_fifo #(
        .WIDTH      (PERIPH_WIDTH),
        .ADDR_WIDTH (FIFO_ADDR_WIDTH)
      ) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_valid[i]),
        .wdata (rx_data[i*PERIPH_WIDTH +: PERIPH_WIDTH]),
        .pop   (receiver_send_acks[i]),
        .rdata (w_rx_head),
        .full  (w_rx_full),
        .empty (w_rx_empty),
        .count (w_rx_count)
      );

      assign w_tx_pop[i] = !w_tx_empty && tx_ready[i];

      uarc_fifo #(
        .WIDTH      (PERIPH_WIDTH),
        .ADDR_WIDTH (FIFO_ADDR_WIDTH)
      ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_tx_push[i]),
        .wdata (w_tx_char),
        .pop   (w_tx_pop[i]),
        .rdata (w_tx_head),
        .full  (w_tx_full),
        .empty (w_tx_empty),
        .count (w_tx_count)
      );

      assign w_rx_status[i].count = c_status_count_width'(w_rx_count);
      assign w_rx_status[i].empty = w_rx_empty;
      assign w_rx_status[i].full  = w_rx_full;
      assign w_tx_status[i].count = c_status_count_width'(w_tx_count);
      assign w_tx_status[i].empty = w_tx_empty;
      assign w_tx_status[i].full  = w_tx_full;

      assign receiver_sends[i] = !w_rx_status[i].empty;
      assign receiver_datas[i*WORD_WIDTH +: WORD_WIDTH] = WORD_WIDTH'(w_rx_head);

      assign tx_valid[i] = !w_tx_status[i].empty;
      assign tx_data[i*PERIPH_WIDTH +: PERIPH_WIDTH] = w_tx_head;
    end
  endgenerate

endmodule : uarc_io_bridge
`default_nettype wire
